// File: rtl/anti_theft_fsm.sv
// anti_theft_fsm: car-alarm control FSM driving the countdown timer.
// Decides arm / trigger / sound / disarm from ignition and door inputs,
// issues a one-cycle timer load strobe with an interval selector and
// drives the siren and status LED. All outputs are registered.
//
// Optional feature macro: PASSENGER_DELAY_EN
//   defined   -> passenger-door trigger selects interval 2 (passenger delay)
//   undefined -> passenger-door trigger selects interval 1 (driver delay)
module anti_theft_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic       expired,
    input  logic       one_hz_enable,
    output logic       start_timer,
    output logic [1:0] interval,
    output logic       siren,
    output logic       status,
    output logic [2:0] EA_DISPLAY
);

    localparam logic [2:0] S_ARMED       = 3'd0;
    localparam logic [2:0] S_TRIGGERED   = 3'd1;
    localparam logic [2:0] S_SOUND_ALARM = 3'd2;
    localparam logic [2:0] S_DISARMED    = 3'd3;
    localparam logic [2:0] S_WAIT_OPEN   = 3'd4;
    localparam logic [2:0] S_WAIT_CLOSE  = 3'd5;
    localparam logic [2:0] S_ARM_DELAY   = 3'd6;

    localparam logic [1:0] IV_ARM    = 2'd0;
    localparam logic [1:0] IV_DRIVER = 2'd1;
    localparam logic [1:0] IV_ALARM  = 2'd3;
`ifdef PASSENGER_DELAY_EN
    localparam logic [1:0] IV_PASS   = 2'd2;
`else
    localparam logic [1:0] IV_PASS   = 2'd1;
`endif

    logic [2:0] state_q, state_d;
    logic       start_q, start_d;
    logic [1:0] interval_q, interval_d;
    logic       blank_q;
    logic       siren_q, siren_d;
    logic       status_q, status_d;
    logic       exp_ok;
    logic       door_open;

    // expired is blanked while the strobe is high and for one cycle after,
    // so a stale completion pulse from a previous countdown cannot act.
    assign exp_ok    = expired & ~start_q & ~blank_q;
    assign door_open = door_driver | door_pass;

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_ARMED;
            start_q    <= 1'b0;
            interval_q <= IV_ARM;
            blank_q    <= 1'b0;
            siren_q    <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            interval_q <= interval_d;
            blank_q    <= start_q;
            siren_q    <= siren_d;
            status_q   <= status_d;
        end
    end

    // Next state, timer strobe and interval selection
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        interval_d = interval_q;
        if (reprogram) begin
            state_d = S_ARMED;
        end else if (ignition && state_q != S_DISARMED) begin
            state_d = S_DISARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    // both doors together count as the driver door
                    if (door_driver) begin
                        state_d    = S_TRIGGERED;
                        interval_d = IV_DRIVER;
                        start_d    = 1'b1;
                    end else if (door_pass) begin
                        state_d    = S_TRIGGERED;
                        interval_d = IV_PASS;
                        start_d    = 1'b1;
                    end
                end
                S_TRIGGERED: begin
                    if (exp_ok) begin
                        state_d    = S_SOUND_ALARM;
                        interval_d = IV_ALARM;
                        start_d    = 1'b1;
                    end
                end
                S_SOUND_ALARM: begin
                    if (exp_ok) begin
                        if (door_open) begin
                            interval_d = IV_ALARM;
                            start_d    = 1'b1;
                        end else begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_DISARMED: begin
                    if (!ignition) state_d = S_WAIT_OPEN;
                end
                S_WAIT_OPEN: begin
                    if (door_driver) state_d = S_WAIT_CLOSE;
                end
                S_WAIT_CLOSE: begin
                    if (!door_open) begin
                        state_d    = S_ARM_DELAY;
                        interval_d = IV_ARM;
                        start_d    = 1'b1;
                    end
                end
                S_ARM_DELAY: begin
                    if (door_open)   state_d = S_WAIT_CLOSE;
                    else if (exp_ok) state_d = S_ARMED;
                end
                default: state_d = S_ARMED;
            endcase
        end
    end

    // Siren and status LED, decoded from the next state so they register
    // alongside it; in ARMED the LED is the square wave one stage late.
    always_comb begin
        siren_d  = (state_d == S_SOUND_ALARM);
        status_d = 1'b0;
        case (state_d)
            S_ARMED:       status_d = one_hz_enable;
            S_TRIGGERED,
            S_SOUND_ALARM,
            S_ARM_DELAY:   status_d = 1'b1;
            default:       status_d = 1'b0;
        endcase
    end

    assign start_timer = start_q;
    assign interval    = interval_q;
    assign siren       = siren_q;
    assign status      = status_q;
    assign EA_DISPLAY  = state_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Scoreboard bench for anti_theft_fsm: each step drives inputs, pushes the
// expected post-edge outputs, then pops and compares after the edge.
module tb_anti_theft_fsm;

    logic       clock = 1'b0;
    logic       reset, ignition, door_driver, door_pass, reprogram, expired, one_hz_enable;
    logic       start_timer, siren, status;
    logic [1:0] interval;
    logic [2:0] EA_DISPLAY;

`ifdef PASSENGER_DELAY_EN
    localparam logic [1:0] PI = 2'd2;
`else
    localparam logic [1:0] PI = 2'd1;
`endif

    typedef struct {
        string      tag;
        logic [2:0] ea;
        logic       sir;
        logic       sts;
        logic       stt;
        logic [1:0] iv;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    anti_theft_fsm dut (
        .clock(clock), .reset(reset), .ignition(ignition),
        .door_driver(door_driver), .door_pass(door_pass), .reprogram(reprogram),
        .expired(expired), .one_hz_enable(one_hz_enable),
        .start_timer(start_timer), .interval(interval), .siren(siren),
        .status(status), .EA_DISPLAY(EA_DISPLAY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs: rst ign dd dp rp ex oh ; expected after edge: ea siren status start interval
    task automatic step(input string tag,
                        input logic rst, ign, dd, dp, rp, ex, oh,
                        input logic [2:0] ea, input logic sir, sts, stt, input logic [1:0] iv);
        exp_t e;
        exp_t g;
        reset = rst; ignition = ign; door_driver = dd; door_pass = dp;
        reprogram = rp; expired = ex; one_hz_enable = oh;
        e.tag = tag; e.ea = ea; e.sir = sir; e.sts = sts; e.stt = stt; e.iv = iv;
        q.push_back(e);
        @(posedge clock);
        #1;
        if (q.size() == 0) begin
            chk({tag, ".queue"}, 4'd0, 4'd1);
        end else begin
            g = q.pop_front();
            chk({g.tag, ".ea"},    {1'b0, EA_DISPLAY}, {1'b0, g.ea});
            chk({g.tag, ".siren"}, {3'b0, siren},      {3'b0, g.sir});
            chk({g.tag, ".status"},{3'b0, status},     {3'b0, g.sts});
            chk({g.tag, ".start"}, {3'b0, start_timer},{3'b0, g.stt});
            chk({g.tag, ".iv"},    {2'b0, interval},   {2'b0, g.iv});
        end
    endtask

    initial begin
        reset = 1; ignition = 0; door_driver = 0; door_pass = 0;
        reprogram = 0; expired = 0; one_hz_enable = 0;
        @(negedge clock);
        //    tag           rst ign dd dp rp ex oh   ea sir sts stt iv
        step("rst0",        1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        step("rst1",        1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        step("arm_oh1",     0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
        step("arm_oh0",     0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        step("arm_oh1b",    0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
        // driver intrusion, with expired pulses inside the blanking window
        step("drv_trig",    0, 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 1);
        step("drv_blank0",  0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 1);
        step("drv_blank1",  0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 1);
        step("drv_sound",   0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 1, 3);
        step("drv_idle0",   0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 3);
        step("drv_idle1",   0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 3);
        step("drv_rearm",   0, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 3);
        // passenger intrusion and door held during alarm
        step("pas_trig",    0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 1, PI);
        step("pas_idle0",   0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, PI);
        step("pas_idle1",   0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, PI);
        step("pas_sound",   0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 1, 3);
        step("hold_idle0",  0, 0, 0, 1, 0, 0, 0,   2, 1, 1, 0, 3);
        step("hold_idle1",  0, 0, 0, 1, 0, 0, 0,   2, 1, 1, 0, 3);
        step("hold_rstrt",  0, 0, 0, 1, 0, 1, 0,   2, 1, 1, 1, 3);
        step("hold_idle2",  0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 3);
        step("hold_idle3",  0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 3);
        step("hold_done",   0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 3);
        // both doors together count as driver
        step("both_trig",   0, 0, 1, 1, 0, 0, 0,   1, 0, 1, 1, 1);
        // disarm and re-arm
        step("dis_ign",     0, 1, 0, 0, 0, 0, 0,   3, 0, 0, 0, 1);
        step("dis_hold",    0, 1, 0, 0, 0, 0, 0,   3, 0, 0, 0, 1);
        step("dis_wopen",   0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 1);
        step("dis_wpass",   0, 0, 0, 1, 0, 0, 0,   4, 0, 0, 0, 1);
        step("dis_wclose",  0, 0, 1, 0, 0, 0, 0,   5, 0, 0, 0, 1);
        step("dis_armdly",  0, 0, 0, 0, 0, 0, 0,   6, 0, 1, 1, 0);
        step("dis_reopen",  0, 0, 1, 0, 0, 0, 0,   5, 0, 0, 0, 0);
        step("dis_armdly2", 0, 0, 0, 0, 0, 0, 0,   6, 0, 1, 1, 0);
        step("dis_blank",   0, 0, 0, 0, 0, 1, 0,   6, 0, 1, 0, 0);
        step("dis_idle",    0, 0, 0, 0, 0, 0, 0,   6, 0, 1, 0, 0);
        step("dis_armed",   0, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 0);
        // priority: reprogram beats ignition in SOUND_ALARM
        step("pri_trig",    0, 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 1);
        step("pri_idle0",   0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1);
        step("pri_idle1",   0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1);
        step("pri_sound",   0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 1, 3);
        step("pri_reprog",  0, 1, 0, 0, 1, 0, 1,   0, 0, 1, 0, 3);
        step("pri_ignarm",  0, 1, 0, 0, 0, 0, 0,   3, 0, 0, 0, 3);
        step("pri_rp_dis",  0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 3);
        // reset mid-timing, later stale expired ignored in ARMED
        step("rmid_trig",   0, 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 1);
        step("rmid_rst",    1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        step("rmid_stale",  0, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 0);
        step("rmid_quiet",  0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        if (q.size() != 0) chk("queue_empty", 4'(q.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
